tipi_pi_nib_xfer: RTL

- Parametrised successor to the TIPI Raspberry Pi nibble-bus transport.
- Carries RD/RC (Pi to TI) and TD/TC (TI to Pi) over an NIB_W-bit lane bus, with configurable word width.
- Adds a synchronised single-clock implementation and burst mode, buffered through RX/TX FIFOs on the data channel.
- Sits between the Pi GPIO pins (r_*) and the TI-side register/latch logic in tipi_top.

---
 rtl/tipi_pkg.sv | 18 +
 rtl/tipi_sync_fifo.sv | 65 ++++++
 rtl/tipi_pi_nib_xfer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tipi_pkg.sv
// Shared definitions for the TIPI Pi nibble-bus transport: command bit
// positions, frame state encoding and default synchroniser depth.
package tipi_pkg;

   localparam int CMD_CTL   = 0;
   localparam int CMD_WR    = 1;
   localparam int CMD_BURST = 2;

   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      CMD    = 2'd0,
      WR     = 2'd1,
      RD_OUT = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/tipi_sync_fifo.sv
// Single-clock show-ahead FIFO. Push when full and pop when empty are dropped;
// a push alongside a pop is accepted at any level short of full.
module tipi_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/tipi_pi_nib_xfer.sv
// Pi-side nibble-bus transport: synchronises the Pi strobe/lanes into clk and
// moves RD/RC/TD/TC words, with burst transfers through RX/TX FIFOs.
//
// state  | meaning
// CMD    | waiting for the command lane of a frame
// WR     | shifting Pi lanes into the accumulator (RD/RC or RX FIFO)
// RD_OUT | presenting snapshot lanes on r_nib_out, oe high
// DONE   | frame complete, events ignored until nibrst
module tipi_pi_nib_xfer
   import tipi_pkg::*;
#(
   parameter int NIB_W       = 4,
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r_clk,
   input  logic              r_nibrst,
   input  logic [NIB_W-1:0]  r_nib_in,
   output logic [NIB_W-1:0]  r_nib_out,
   output logic              r_nib_oe,
   input  logic [DATA_W-1:0] td_in,
   input  logic [DATA_W-1:0] tc_in,
   output logic [DATA_W-1:0] rd_q,
   output logic [DATA_W-1:0] rc_q,
   output logic              rd_stb,
   output logic              rc_stb,
   input  logic              rx_pop,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_empty,
   input  logic              tx_push,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_full,
   output logic              ovf,
   output logic              udf,
   input  logic              flag_clr
);

   localparam int LANES = DATA_W / NIB_W;
   localparam int CW    = $clog2(LANES + 1);

   // lane idx 0 is the most significant lane of the word
   function automatic logic [NIB_W-1:0] lane_sel(input logic [DATA_W-1:0] w,
                                                 input logic [CW-1:0] idx);
      logic [DATA_W-1:0] tmp;
      tmp = w >> (NIB_W * (LANES - 1 - int'(idx)));
      return tmp[NIB_W-1:0];
   endfunction

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
   logic [NIB_W-1:0]       nib_sync_q [SYNC_STAGES];
   logic [NIB_W-1:0]       nib_sync_d [SYNC_STAGES];
   logic                   clk_prev_q, clk_prev_d;
   logic                   clk_s, nibrst_s, evt;
   logic [NIB_W-1:0]       nib_s;

   always_comb begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
         if (i == 0) begin
            clk_sync_d[i] = r_clk;
            rst_sync_d[i] = r_nibrst;
            nib_sync_d[i] = r_nib_in;
         end else begin
            clk_sync_d[i] = clk_sync_q[i-1];
            rst_sync_d[i] = rst_sync_q[i-1];
            nib_sync_d[i] = nib_sync_q[i-1];
         end
      end
   end

   assign clk_s      = clk_sync_q[SYNC_STAGES-1];
   assign nibrst_s   = rst_sync_q[SYNC_STAGES-1];
   assign nib_s      = nib_sync_q[SYNC_STAGES-1];
   assign clk_prev_d = clk_s;
   assign evt        = clk_s & ~clk_prev_q;

   state_e            state_q, state_d;
   logic [CW-1:0]     lane_cnt_q, lane_cnt_d;
   logic              ctl_q, ctl_d;
   logic              burst_q, burst_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] snap_q, snap_d;
   logic [NIB_W-1:0]  nib_out_q, nib_out_d;
   logic              oe_q, oe_d;
   logic [DATA_W-1:0] rd_word_q, rd_word_d;
   logic [DATA_W-1:0] rc_word_q, rc_word_d;
   logic              rd_stb_q, rd_stb_d;
   logic              rc_stb_q, rc_stb_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic              rx_push, rx_full;
   logic              tx_pop, tx_empty;
   logic [DATA_W-1:0] tx_head;
   logic [DATA_W-1:0] acc_shift;
   logic [DATA_W+NIB_W-1:0] acc_wide;
   logic              ovf_set, udf_set;

   assign acc_wide  = {acc_q, nib_s};
   assign acc_shift = acc_wide[DATA_W-1:0];

   always_comb begin
      state_d    = state_q;
      lane_cnt_d = lane_cnt_q;
      ctl_d      = ctl_q;
      burst_d    = burst_q;
      acc_d      = acc_q;
      snap_d     = snap_q;
      nib_out_d  = nib_out_q;
      oe_d       = oe_q;
      rd_word_d  = rd_word_q;
      rc_word_d  = rc_word_q;
      rd_stb_d   = 1'b0;
      rc_stb_d   = 1'b0;
      rx_push    = 1'b0;
      tx_pop     = 1'b0;
      ovf_set    = 1'b0;
      udf_set    = 1'b0;

      if (nibrst_s) begin
         state_d    = CMD;
         lane_cnt_d = '0;
         oe_d       = 1'b0;
         acc_d      = '0;
         nib_out_d  = '0;
      end else if (evt) begin
         case (state_q)
            CMD: begin
               ctl_d      = nib_s[CMD_CTL];
               burst_d    = nib_s[CMD_BURST] & ~nib_s[CMD_CTL];
               lane_cnt_d = '0;
               acc_d      = '0;
               nib_out_d  = '0;
               if (nib_s[CMD_WR]) begin
                  state_d = WR;
               end else begin
                  state_d = RD_OUT;
                  oe_d    = 1'b1;
                  if (nib_s[CMD_CTL]) begin
                     snap_d = tc_in;
                  end else if (nib_s[CMD_BURST]) begin
                     snap_d  = tx_empty ? '0 : tx_head;
                     tx_pop  = ~tx_empty;
                     udf_set = tx_empty;
                  end else begin
                     snap_d = td_in;
                  end
               end
            end
            WR: begin
               acc_d = acc_shift;
               if (lane_cnt_q == CW'(LANES - 1)) begin
                  lane_cnt_d = '0;
                  if (burst_q) begin
                     rx_push = ~rx_full;
                     ovf_set = rx_full;
                  end else begin
                     state_d = DONE;
                     if (ctl_q) begin
                        rc_word_d = acc_shift;
                        rc_stb_d  = 1'b1;
                     end else begin
                        rd_word_d = acc_shift;
                        rd_stb_d  = 1'b1;
                     end
                  end
               end else begin
                  lane_cnt_d = lane_cnt_q + CW'(1);
               end
            end
            RD_OUT: begin
               if (lane_cnt_q == CW'(LANES)) begin
                  if (burst_q) begin
                     // fetch the next word and present its MSB lane at once
                     snap_d     = tx_empty ? '0 : tx_head;
                     tx_pop     = ~tx_empty;
                     udf_set    = tx_empty;
                     nib_out_d  = tx_empty ? '0 : lane_sel(tx_head, '0);
                     lane_cnt_d = CW'(1);
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  nib_out_d  = lane_sel(snap_q, lane_cnt_q);
                  lane_cnt_d = lane_cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end

      ovf_d = ovf_set | (ovf_q & ~flag_clr);
      udf_d = udf_set | (udf_q & ~flag_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q <= '0;
         rst_sync_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) nib_sync_q[i] <= '0;
         clk_prev_q <= 1'b0;
         state_q    <= CMD;
         lane_cnt_q <= '0;
         ctl_q      <= 1'b0;
         burst_q    <= 1'b0;
         acc_q      <= '0;
         snap_q     <= '0;
         nib_out_q  <= '0;
         oe_q       <= 1'b0;
         rd_word_q  <= '0;
         rc_word_q  <= '0;
         rd_stb_q   <= 1'b0;
         rc_stb_q   <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         rst_sync_q <= rst_sync_d;
         nib_sync_q <= nib_sync_d;
         clk_prev_q <= clk_prev_d;
         state_q    <= state_d;
         lane_cnt_q <= lane_cnt_d;
         ctl_q      <= ctl_d;
         burst_q    <= burst_d;
         acc_q      <= acc_d;
         snap_q     <= snap_d;
         nib_out_q  <= nib_out_d;
         oe_q       <= oe_d;
         rd_word_q  <= rd_word_d;
         rc_word_q  <= rc_word_d;
         rd_stb_q   <= rd_stb_d;
         rc_stb_q   <= rc_stb_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   tipi_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (acc_shift),
      .rdata (rx_data),
      .empty (rx_empty),
      .full  (rx_full)
   );

   tipi_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (tx_data),
      .rdata (tx_head),
      .empty (tx_empty),
      .full  (tx_full)
   );

   assign r_nib_out = nib_out_q;
   assign r_nib_oe  = oe_q;
   assign rd_q      = rd_word_q;
   assign rc_q      = rc_word_q;
   assign rd_stb    = rd_stb_q;
   assign rc_stb    = rc_stb_q;
   assign ovf       = ovf_q;
   assign udf       = udf_q;

endmodule
